// File: rtl/char_spawner_pkg.sv
// rtl/char_spawner_pkg.sv - shared constants, FSM encoding and slot/letter helpers
package char_spawner_pkg;

  localparam int         NSLOTS_MAX  = 64;
  localparam int         CHAR_W      = 16;
  localparam logic [7:0] ASCII_A     = 8'h41;
  localparam logic [7:0] ASCII_BLANK = 8'h00;
  localparam int         NLETTERS    = 26;

  // Shared with the keyboard matcher, so the encoding is fixed here.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PROBE = 2'd1,
    ST_WRITE = 2'd2,
    ST_KILL  = 2'd3
  } spawn_state_e;

  // Reduce a 6-bit random value into 0..n-1 by repeated subtraction.
  function automatic logic [5:0] mod_slots(input logic [5:0] v, input int n);
    logic [5:0] r;
    r = v;
    for (int i = 0; i < NSLOTS_MAX; i++) begin
      if (int'(r) >= n) r = r - 6'(n);
    end
    return r;
  endfunction

  // Map a 5-bit random value onto 'A'..'Z'.
  function automatic logic [7:0] letter_of(input logic [4:0] v);
    logic [4:0] r;
    r = v;
    if (r >= 5'(NLETTERS)) r = r - 5'(NLETTERS);
    return ASCII_A + {3'b000, r};
  endfunction

endpackage

// File: rtl/char_spawner_lfsr16.sv
// rtl/char_spawner_lfsr16.sv - free-running 16-bit Galois LFSR
module lfsr16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] q_q, q_d;
  logic [15:0] seed_nz;

  // An all-zero state would lock the LFSR, so a zero seed becomes 1.
  assign seed_nz = (seed == 16'h0000) ? 16'h0001 : seed;

  // Right-shifting Galois step for x^16+x^14+x^13+x^11+1.
  always_comb begin
    q_d = {1'b0, q_q[15:1]};
    if (q_q[0]) q_d = q_d ^ 16'hB400;
  end

  // State register; advances every cycle out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= seed_nz;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/char_spawner.sv
// rtl/char_spawner.sv - periodic falling-character spawner with kill service
module char_spawner
  import char_spawner_pkg::*;
#(
  parameter int          NSLOTS    = 40,
  parameter int          SPAWN_DIV = 25_000_000,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              kill_valid,
  input  logic [5:0]        kill_slot,
  output logic              kill_ready,
  output logic              wr_en,
  output logic [11:0]       wr_addr,
  output logic [7:0]        wr_data,
  output logic [NSLOTS-1:0] slot_valid,
  output logic              new_valid,
  output logic [5:0]        new_slot,
  output logic [2:0]        new_speed,
  output logic [6:0]        live_count
);

  localparam int TW = $clog2(SPAWN_DIV);

  logic [15:0] lfsr;
  logic        unused_lfsr_bits;

  spawn_state_e    state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            pending_q, pending_d;
  logic [5:0]      cand_q, cand_d;
  logic [7:0]      letter_q, letter_d;
  logic [2:0]      speed_q, speed_d;
  logic [NSLOTS-1:0] slot_q, slot_d;
  logic [6:0]      count_q, count_d;
  logic            wr_en_q, wr_en_d;
  logic [11:0]     wr_addr_q, wr_addr_d;
  logic [7:0]      wr_data_q, wr_data_d;
  logic            new_valid_q, new_valid_d;
  logic [5:0]      new_slot_q, new_slot_d;
  logic [2:0]      new_speed_q, new_speed_d;

  logic                  tick;
  logic                  consume;
  logic                  kill_hit;
  logic [NSLOTS_MAX-1:0] slot_pad;
  logic [NSLOTS_MAX-1:0] kill_mask;
  logic [NSLOTS_MAX-1:0] cand_mask;

  lfsr16 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .seed  (LFSR_SEED),
    .q     (lfsr)
  );

  assign unused_lfsr_bits = ^{lfsr[7:6], lfsr[13]};

  // Zero-padded bitmap: slots beyond NSLOTS always read as empty.
  assign slot_pad  = NSLOTS_MAX'(slot_q);
  assign kill_mask = NSLOTS_MAX'(1) << kill_slot;
  assign cand_mask = NSLOTS_MAX'(1) << cand_q;
  assign kill_hit  = ({1'b0, kill_slot} < 7'(NSLOTS)) && slot_pad[kill_slot];

  // Spawn timer; a wrap raises pending, which merges further ticks until served.
  always_comb begin
    tick      = enable && (timer_q == TW'(SPAWN_DIV - 1));
    timer_d   = timer_q;
    pending_d = pending_q;
    if (enable) timer_d = tick ? '0 : timer_q + TW'(1);
    if (consume) pending_d = 1'b0;
    if (tick)    pending_d = 1'b1;
    if (!enable) pending_d = 1'b0;
  end

  // FSM next state plus the registered write/announce outputs and bitmap updates.
  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    letter_d    = letter_q;
    speed_d     = speed_q;
    slot_d      = slot_q;
    count_d     = count_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    new_valid_d = 1'b0;
    new_slot_d  = new_slot_q;
    new_speed_d = new_speed_q;
    consume     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (kill_valid) begin
          state_d = ST_KILL;
          if (kill_hit) begin
            wr_en_d   = 1'b1;
            wr_addr_d = {6'b000000, kill_slot};
            wr_data_d = ASCII_BLANK;
            slot_d    = slot_q & ~kill_mask[NSLOTS-1:0];
            count_d   = count_q - 7'd1;
          end
        end else if (pending_q && enable) begin
          consume = 1'b1;
          // A full screen drops the spawn instead of probing forever.
          if (count_q != 7'(NSLOTS)) begin
            cand_d   = mod_slots(lfsr[5:0], NSLOTS);
            letter_d = letter_of(lfsr[12:8]);
            speed_d  = {1'b0, lfsr[15:14]} + 3'd1;
            state_d  = ST_PROBE;
          end
        end
      end
      ST_PROBE: begin
        if (!slot_pad[cand_q]) begin
          state_d     = ST_WRITE;
          wr_en_d     = 1'b1;
          wr_addr_d   = {6'b000000, cand_q};
          wr_data_d   = letter_q;
          new_valid_d = 1'b1;
          new_slot_d  = cand_q;
          new_speed_d = speed_q;
          slot_d      = slot_q | cand_mask[NSLOTS-1:0];
          count_d     = count_q + 7'd1;
        end else begin
          cand_d = (cand_q == 6'(NSLOTS - 1)) ? 6'd0 : cand_q + 6'd1;
        end
      end
      ST_WRITE: state_d = ST_IDLE;
      ST_KILL:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // All state and output registers; reset abandons any write in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      pending_q   <= 1'b0;
      cand_q      <= '0;
      letter_q    <= '0;
      speed_q     <= '0;
      slot_q      <= '0;
      count_q     <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      new_valid_q <= 1'b0;
      new_slot_q  <= '0;
      new_speed_q <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      pending_q   <= pending_d;
      cand_q      <= cand_d;
      letter_q    <= letter_d;
      speed_q     <= speed_d;
      slot_q      <= slot_d;
      count_q     <= count_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      new_valid_q <= new_valid_d;
      new_slot_q  <= new_slot_d;
      new_speed_q <= new_speed_d;
    end
  end

  assign kill_ready = (state_q == ST_IDLE);
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign slot_valid = slot_q;
  assign new_valid  = new_valid_q;
  assign new_slot   = new_slot_q;
  assign new_speed  = new_speed_q;
  assign live_count = count_q;

endmodule

// File: tb/tb_char_spawner.sv
// tb/tb_char_spawner.sv - directed self-checking bench for char_spawner
module tb_char_spawner;

  localparam int NS = 40;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        kill_valid;
  logic [5:0]  kill_slot;
  logic        kill_ready;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;
  logic [NS-1:0] slot_valid;
  logic        new_valid;
  logic [5:0]  new_slot;
  logic [2:0]  new_speed;
  logic [6:0]  live_count;

  int total = 0;
  int bad   = 0;
  int en_cnt = 0;

  logic [15:0]   lfsr_m;
  logic [NS-1:0] m_bits;
  int            m_live;

  always #5 clk = ~clk;

  char_spawner #(.NSLOTS(NS), .SPAWN_DIV(8), .LFSR_SEED(16'hACE1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .kill_valid (kill_valid),
    .kill_slot  (kill_slot),
    .kill_ready (kill_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .slot_valid (slot_valid),
    .new_valid  (new_valid),
    .new_slot   (new_slot),
    .new_speed  (new_speed),
    .live_count (live_count)
  );

  // Reference LFSR: x^16+x^14+x^13+x^11+1, Galois form, mask 0xB400.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    logic [15:0] r;
    r = v >> 1;
    if (v[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_m <= 16'hACE1;
    else        lfsr_m <= lfsr_next(lfsr_m);
  end

  function automatic int probe_len(input int c);
    int  p;
    int  s;
    logic done;
    p = 0; s = c; done = 1'b0;
    for (int i = 0; i < NS; i++) begin
      if (!done) begin
        if (m_bits[s]) begin
          s = (s == NS - 1) ? 0 : s + 1;
          p++;
        end else begin
          done = 1'b1;
        end
      end
    end
    return p;
  endfunction

  task automatic step();
    @(posedge clk);
    if (enable && rst_n) en_cnt++;
    #1;
  endtask

  task automatic finish_spawn(input logic [15:0] dec, inout int n);
    int         c, p, s, x;
    logic [7:0] let_e;
    logic [2:0] spd_e;
    c = int'(dec[5:0]);
    if (c >= NS) c = c - NS;
    x = int'(dec[12:8]);
    if (x >= 26) x = x - 26;
    let_e = 8'(65 + x);
    spd_e = 3'(int'(dec[15:14]) + 1);
    p = probe_len(c);
    s = (c + p) % NS;
    for (int i = 0; i < p; i++) begin
      step(); n++;
      total++;
      if (wr_en !== 1'b0) begin
        bad++;
        $display("FAIL probe_quiet: wr_en=%0b during probe %0d, expected 0", wr_en, i);
      end
    end
    step(); n++;
    total++;
    if (wr_en !== 1'b1 || wr_addr !== 12'(s) || wr_data !== let_e) begin
      bad++;
      $display("FAIL spawn_write: wr_en=%0b addr=%0d data=%h, expected 1 addr=%0d data=%h",
               wr_en, wr_addr, wr_data, s, let_e);
    end
    total++;
    if (new_valid !== 1'b1 || new_slot !== 6'(s) || new_speed !== spd_e || kill_ready !== 1'b0) begin
      bad++;
      $display("FAIL spawn_new: new_valid=%0b slot=%0d speed=%0d ready=%0b, expected 1 slot=%0d speed=%0d ready=0",
               new_valid, new_slot, new_speed, kill_ready, s, spd_e);
    end
    m_bits[s] = 1'b1;
    m_live++;
    step(); n++;
    total++;
    if (wr_en !== 1'b0 || new_valid !== 1'b0) begin
      bad++;
      $display("FAIL spawn_pulse: wr_en=%0b new_valid=%0b after write, expected 0 0", wr_en, new_valid);
    end
    total++;
    if (slot_valid !== m_bits || live_count !== 7'(m_live)) begin
      bad++;
      $display("FAIL spawn_state: slot_valid=%h live=%0d, expected %h live=%0d",
               slot_valid, live_count, m_bits, m_live);
    end
  endtask

  task automatic do_spawn(output int n);
    logic [15:0] dec;
    n = 0;
    enable = 1'b1;
    do begin step(); n++; end while (en_cnt % 8 != 0);
    dec = lfsr_m;
    step(); n++;
    enable = 1'b0;
    finish_spawn(dec, n);
  endtask

  task automatic do_kill(input int s);
    logic hit;
    hit = (s < NS) ? m_bits[s] : 1'b0;
    kill_valid = 1'b1;
    kill_slot  = 6'(s);
    total++;
    if (kill_ready !== 1'b1) begin
      bad++;
      $display("FAIL kill_ready_idle: kill_ready=%0b, expected 1", kill_ready);
    end
    step();
    kill_valid = 1'b0;
    total++;
    if (wr_en !== hit || new_valid !== 1'b0 ||
        (hit && (wr_addr !== 12'(s) || wr_data !== 8'h00))) begin
      bad++;
      $display("FAIL kill_write slot %0d: wr_en=%0b addr=%0d data=%h new_valid=%0b, expected wr_en=%0b addr=%0d data=00 new_valid=0",
               s, wr_en, wr_addr, wr_data, new_valid, hit, s);
    end
    if (hit) begin
      m_bits[s] = 1'b0;
      m_live--;
    end
    total++;
    if (kill_ready !== 1'b0) begin
      bad++;
      $display("FAIL kill_busy: kill_ready=%0b in KILL, expected 0", kill_ready);
    end
    step();
    total++;
    if (wr_en !== 1'b0 || kill_ready !== 1'b1 || slot_valid !== m_bits || live_count !== 7'(m_live)) begin
      bad++;
      $display("FAIL kill_after slot %0d: wr_en=%0b ready=%0b slot_valid=%h live=%0d, expected 0 1 %h %0d",
               s, wr_en, kill_ready, slot_valid, live_count, m_bits, m_live);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; kill_valid = 1'b0; kill_slot = 6'd0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (wr_en !== 1'b0 || slot_valid !== '0 || live_count !== 7'd0 || kill_ready !== 1'b1 || new_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_values: wr_en=%0b slot_valid=%h live=%0d ready=%0b new_valid=%0b, expected 0 0 0 1 0",
               wr_en, slot_valid, live_count, kill_ready, new_valid);
    end
    rst_n = 1'b1;
    en_cnt = 0; m_bits = '0; m_live = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      total++;
      if (wr_en !== 1'b0 || slot_valid !== '0 || live_count !== 7'd0 || kill_ready !== 1'b1) begin
        bad++;
        $display("FAIL reset_idle cycle %0d: wr_en=%0b slot_valid=%h live=%0d ready=%0b, expected 0 0 0 1",
                 i, wr_en, slot_valid, live_count, kill_ready);
      end
    end
  endtask

  task automatic test_single_spawn();
    int n;
    do_spawn(n);
    total++;
    if (n !== 11) begin
      bad++;
      $display("FAIL first_latency: write seen after edge %0d of enable, expected edge 10", n - 1);
    end
    total++;
    if (live_count !== 7'd1) begin
      bad++;
      $display("FAIL first_live: live_count=%0d, expected 1", live_count);
    end
  endtask

  task automatic test_fill();
    int n;
    while (m_live < NS) do_spawn(n);
    total++;
    if (slot_valid !== {NS{1'b1}} || live_count !== 7'd40) begin
      bad++;
      $display("FAIL fill: slot_valid=%h live=%0d, expected all ones live=40", slot_valid, live_count);
    end
  endtask

  task automatic test_full();
    int n;
    enable = 1'b1;
    do step(); while (en_cnt % 8 != 0);
    step();
    total++;
    if (wr_en !== 1'b0 || kill_ready !== 1'b1 || live_count !== 7'd40) begin
      bad++;
      $display("FAIL full_drop: wr_en=%0b ready=%0b live=%0d, expected 0 1 40", wr_en, kill_ready, live_count);
    end
    do_kill(2);
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (wr_en !== 1'b0) begin
        bad++;
        $display("FAIL full_pending_cleared: wr_en=%0b at cycle %0d after kill, expected 0", wr_en, i);
      end
    end
    enable = 1'b0;
    do_spawn(n);
    total++;
    if (slot_valid !== {NS{1'b1}}) begin
      bad++;
      $display("FAIL wrap_fill: slot_valid=%h, expected all ones", slot_valid);
    end
  endtask

  task automatic test_kill();
    int n;
    do_kill(7);
    do_kill(45);
    do_kill(7);
    do_spawn(n);
    total++;
    if (slot_valid !== {NS{1'b1}} || live_count !== 7'd40) begin
      bad++;
      $display("FAIL kill_refill: slot_valid=%h live=%0d, expected all ones 40", slot_valid, live_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] dec;
    int n;
    enable = 1'b1;
    do step(); while (en_cnt % 8 != 0);
    kill_valid = 1'b1; kill_slot = 6'd11;
    step();
    kill_valid = 1'b0;
    total++;
    if (wr_en !== 1'b1 || wr_addr !== 12'd11 || wr_data !== 8'h00 || new_valid !== 1'b0) begin
      bad++;
      $display("FAIL collide_kill_first: wr_en=%0b addr=%0d data=%h new_valid=%0b, expected 1 11 00 0",
               wr_en, wr_addr, wr_data, new_valid);
    end
    m_bits[11] = 1'b0; m_live--;
    step();
    total++;
    if (wr_en !== 1'b0 || kill_ready !== 1'b1) begin
      bad++;
      $display("FAIL collide_idle: wr_en=%0b ready=%0b, expected 0 1", wr_en, kill_ready);
    end
    dec = lfsr_m;
    step();
    enable = 1'b0;
    n = 0;
    finish_spawn(dec, n);
    total++;
    if (slot_valid !== {NS{1'b1}}) begin
      bad++;
      $display("FAIL collide_spawn: slot_valid=%h, expected all ones", slot_valid);
    end
  endtask

  task automatic test_reset_probe();
    int n;
    do_kill(20);
    enable = 1'b1;
    do step(); while (en_cnt % 8 != 0);
    step();
    rst_n = 1'b0;
    #1;
    total++;
    if (wr_en !== 1'b0 || new_valid !== 1'b0 || slot_valid !== '0 || live_count !== 7'd0 ||
        kill_ready !== 1'b1 || wr_addr !== 12'd0 || wr_data !== 8'h00 || new_slot !== 6'd0 || new_speed !== 3'd0) begin
      bad++;
      $display("FAIL async_reset: wr_en=%0b new_valid=%0b slot_valid=%h live=%0d ready=%0b addr=%0d data=%h, expected 0 0 0 0 1 0 00",
               wr_en, new_valid, slot_valid, live_count, kill_ready, wr_addr, wr_data);
    end
    enable = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    en_cnt = 0; m_bits = '0; m_live = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      total++;
      if (wr_en !== 1'b0 || live_count !== 7'd0) begin
        bad++;
        $display("FAIL post_reset_quiet cycle %0d: wr_en=%0b live=%0d, expected 0 0", i, wr_en, live_count);
      end
    end
    do_spawn(n);
    total++;
    if (n !== 11) begin
      bad++;
      $display("FAIL post_reset_latency: write seen after edge %0d, expected edge 10", n - 1);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: still running at %0t, expected finish before 5000000", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_spawn();
    test_fill();
    test_full();
    test_kill();
    test_back_to_back();
    test_reset_probe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
